// File: rtl/conv1_out_serializer.sv
// Buffers conv1_layer result vectors and replays them one channel word per beat over valid/ready.
// Optional macro SER_RELU_EN clamps negative words to zero at the buffer read.
module conv1_out_serializer #(
    parameter int DATA_W = 32,
    parameter int NUM_CH = 32,
    parameter int DEPTH  = 2
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        valid_in,
    input  logic [DATA_W-1:0]           vec_in [0:NUM_CH-1],
    output logic [DATA_W-1:0]           data_out,
    output logic                        valid_out,
    input  logic                        ready_in,
    output logic [$clog2(NUM_CH)-1:0]   ch_idx,
    output logic                        last,
    output logic [$clog2(DEPTH):0]      vec_cnt,
    output logic                        overflow
);
    localparam int CH_W  = $clog2(NUM_CH);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);
    localparam logic [CH_W-1:0]  CH_LAST  = CH_W'(NUM_CH - 1);
    localparam logic [CH_W-1:0]  CH_ZERO  = CH_W'(0);
    localparam logic [CH_W-1:0]  CH_ONE   = CH_W'(1);
    localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);

    typedef enum logic {S_IDLE = 1'b0, S_SEND = 1'b1} state_t;

    state_t              state_q, state_d;
    logic [DATA_W-1:0]   mem_q [DEPTH][NUM_CH];
    logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CH_W-1:0]     ch_q, ch_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                ovf_q, ovf_d;
    logic [DATA_W-1:0]   data_q, data_d;
    logic                valid_q, valid_d;
    logic                last_q, last_d;
    logic                beat_s, last_beat_s, accept_s;

    function automatic logic [DATA_W-1:0] out_word(input logic [DATA_W-1:0] w);
`ifdef SER_RELU_EN
        return w[DATA_W-1] ? {DATA_W{1'b0}} : w;
`else
        return w;
`endif
    endfunction

    // Next-state: capture/drop decision, beat advance, occupancy and registered output words.
    always_comb begin
        beat_s      = valid_q && ready_in;
        last_beat_s = beat_s && last_q;
        // A full buffer still accepts when the head vector frees its entry on this edge.
        accept_s    = valid_in && ((cnt_q != CNT_FULL) || last_beat_s);

        state_d  = state_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        ch_d     = ch_q;
        cnt_d    = cnt_q;
        ovf_d    = ovf_q;

        if (accept_s) begin
            wr_ptr_d = wr_ptr_q + PTR_ONE;
        end else begin
            ovf_d = ovf_q | valid_in;
        end

        case ({accept_s, last_beat_s})
            2'b10:   cnt_d = cnt_q + CNT_ONE;
            2'b01:   cnt_d = cnt_q - CNT_ONE;
            default: cnt_d = cnt_q;
        endcase

        if (beat_s) begin
            if (last_q) begin
                ch_d     = CH_ZERO;
                rd_ptr_d = rd_ptr_q + PTR_ONE;
            end else begin
                ch_d = ch_q + CH_ONE;
            end
        end else begin
            ch_d = ch_q;
        end

        case (state_q)
            S_IDLE: begin
                if (cnt_q != CNT_ZERO) begin
                    state_d = S_SEND;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_SEND: begin
                // A vector accepted on this same edge is not yet readable, so it waits one idle cycle.
                if (last_beat_s) begin
                    state_d = (cnt_q > CNT_ONE) ? S_SEND : S_IDLE;
                end else begin
                    state_d = S_SEND;
                end
            end
            default: state_d = S_IDLE;
        endcase

        valid_d = (state_d == S_SEND);
        last_d  = valid_d && (ch_d == CH_LAST);
        if (valid_d) begin
            data_d = out_word(mem_q[rd_ptr_d][ch_d]);
        end else begin
            data_d = {DATA_W{1'b0}};
        end
    end

    // Control state and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            wr_ptr_q <= {PTR_W{1'b0}};
            rd_ptr_q <= {PTR_W{1'b0}};
            ch_q     <= CH_ZERO;
            cnt_q    <= CNT_ZERO;
            ovf_q    <= 1'b0;
            data_q   <= {DATA_W{1'b0}};
            valid_q  <= 1'b0;
            last_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            ch_q     <= ch_d;
            cnt_q    <= cnt_d;
            ovf_q    <= ovf_d;
            data_q   <= data_d;
            valid_q  <= valid_d;
            last_q   <= last_d;
        end
    end

    // Vector storage; contents need no reset.
    always_ff @(posedge clk) begin
        if (accept_s) begin
            for (int i = 0; i < NUM_CH; i++) begin
                mem_q[wr_ptr_q][i] <= vec_in[i];
            end
        end
    end

    assign data_out  = data_q;
    assign valid_out = valid_q;
    assign ch_idx    = ch_q;
    assign last      = last_q;
    assign vec_cnt   = cnt_q;
    assign overflow  = ovf_q;
endmodule

// File: tb/tb_conv1_out_serializer.sv
// Randomized and directed bench for conv1_out_serializer against a queue-of-vectors reference model.
module tb_conv1_out_serializer;
    localparam int DATA_W = 32;
    localparam int NUM_CH = 32;
    localparam int DEPTH  = 2;

    typedef logic [DATA_W-1:0] vec_t [NUM_CH];

    logic               clk;
    logic               rst_n;
    logic               valid_in;
    logic [DATA_W-1:0]  vec_in [0:NUM_CH-1];
    logic [DATA_W-1:0]  data_out;
    logic               valid_out;
    logic               ready_in;
    logic [4:0]         ch_idx;
    logic               last;
    logic [1:0]         vec_cnt;
    logic               overflow;

    int n_checks;
    int n_errors;

    // Reference model: buffered vectors in arrival order, head beat index, sending flag, sticky overflow.
    vec_t mq[$];
    int   m_bi;
    bit   m_send;
    bit   m_ovf;

    conv1_out_serializer #(.DATA_W(DATA_W), .NUM_CH(NUM_CH), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n), .valid_in(valid_in), .vec_in(vec_in),
        .data_out(data_out), .valid_out(valid_out), .ready_in(ready_in),
        .ch_idx(ch_idx), .last(last), .vec_cnt(vec_cnt), .overflow(overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%h expected=%h t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] ref_word(input logic [31:0] w);
`ifdef SER_RELU_EN
        if ($signed(w) < 0) return 32'd0;
`endif
        return w;
    endfunction

    task automatic model_clear();
        mq.delete();
        m_bi   = 0;
        m_send = 1'b0;
        m_ovf  = 1'b0;
    endtask

    // Compare against the model at the negedge, then advance model and DUT by one rising edge.
    task automatic tick();
        bit   hs, lastb, acc, nsend;
        vec_t v;
        @(negedge clk);
        check_val("valid_out", {31'd0, valid_out}, {31'd0, m_send});
        check_val("vec_cnt", {30'd0, vec_cnt}, mq.size());
        check_val("overflow", {31'd0, overflow}, {31'd0, m_ovf});
        if (m_send) begin
            check_val("data_out", data_out, ref_word(mq[0][m_bi]));
            check_val("ch_idx", {27'd0, ch_idx}, m_bi);
            check_val("last", {31'd0, last}, {31'd0, (m_bi == NUM_CH - 1)});
        end
        hs    = m_send && ready_in;
        lastb = hs && (m_bi == NUM_CH - 1);
        acc   = valid_in && ((mq.size() < DEPTH) || lastb);
        if (valid_in && !acc) m_ovf = 1'b1;
        if (m_send) nsend = lastb ? (mq.size() > 1) : 1'b1;
        else        nsend = (mq.size() > 0);
        if (hs) m_bi = lastb ? 0 : m_bi + 1;
        if (lastb) void'(mq.pop_front());
        if (acc) begin
            for (int i = 0; i < NUM_CH; i++) v[i] = vec_in[i];
            mq.push_back(v);
        end
        m_send = nsend;
        @(posedge clk);
        #1;
    endtask

    task automatic check_zero_outputs(input string tag);
        check_val({tag, "_data"}, data_out, 32'd0);
        check_val({tag, "_valid"}, {31'd0, valid_out}, 32'd0);
        check_val({tag, "_ch"}, {27'd0, ch_idx}, 32'd0);
        check_val({tag, "_last"}, {31'd0, last}, 32'd0);
        check_val({tag, "_cnt"}, {30'd0, vec_cnt}, 32'd0);
        check_val({tag, "_ovf"}, {31'd0, overflow}, 32'd0);
    endtask

    // Short async reset pulse between edges; outputs must clear immediately.
    task automatic pulse_reset(input string tag);
        rst_n = 1'b0;
        #1;
        check_zero_outputs(tag);
        #2;
        rst_n = 1'b1;
        model_clear();
    endtask

    task automatic set_vec_rand();
        for (int i = 0; i < NUM_CH; i++) vec_in[i] = $urandom;
    endtask

    task automatic set_vec_base(input logic [31:0] base);
        for (int i = 0; i < NUM_CH; i++) vec_in[i] = base + 32'(i);
    endtask

    task automatic pulse_vec();
        valid_in = 1'b1;
        tick();
        valid_in = 1'b0;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        model_clear();
        rst_n    = 1'b0;
        valid_in = 1'b0;
        ready_in = 1'b0;
        set_vec_base(32'd0);
        #3;
        check_zero_outputs("reset");
        #9;
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Mid-SEND reset at channel 5, then a k-valued vector.
        set_vec_rand();
        pulse_vec();
        ready_in = 1'b1;
        for (int i = 0; i < 40 && !(m_send && m_bi == 5); i++) tick();
        check_val("reach_ch5", {27'd0, ch_idx}, 32'd5);
        pulse_reset("midreset");
        run(3);
        set_vec_base(32'd0);
        pulse_vec();
        run(40);

        // Single vector, ready held high.
        set_vec_base(32'h1000);
        pulse_vec();
        run(40);
        check_val("single_cnt", {30'd0, vec_cnt}, 32'd0);

        // Backpressure pattern 1,0,0,1.
        set_vec_rand();
        pulse_vec();
        for (int i = 0; i < 140; i++) begin
            ready_in = ((i % 4) == 0) || ((i % 4) == 3);
            tick();
        end

        // Overflow: three vectors into a blocked two-entry buffer.
        ready_in = 1'b0;
        for (int j = 0; j < 3; j++) begin
            set_vec_base(32'hA000_0000 + 32'(j) * 32'h0100_0000);
            pulse_vec();
            tick();
        end
        check_val("ovf_cnt", {30'd0, vec_cnt}, 32'd2);
        check_val("ovf_flag", {31'd0, overflow}, 32'd1);
        ready_in = 1'b1;
        run(80);
        pulse_reset("postovf");
        run(2);

        // Simultaneous accept on the last beat of a full buffer.
        ready_in = 1'b0;
        set_vec_base(32'hA000);
        pulse_vec();
        set_vec_base(32'hB000);
        pulse_vec();
        run(2);
        ready_in = 1'b1;
        for (int i = 0; i < 50 && !(m_send && m_bi == NUM_CH - 1); i++) tick();
        check_val("sim_last", {31'd0, last}, 32'd1);
        set_vec_base(32'hC000);
        pulse_vec();
        check_val("sim_cnt", {30'd0, vec_cnt}, 32'd2);
        check_val("sim_ovf", {31'd0, overflow}, 32'd0);
        run(80);

        // Sign handling on channels 3 and 4.
        set_vec_rand();
        vec_in[3] = 32'hFFFF_FFF0;
        vec_in[4] = 32'h0000_0010;
        pulse_vec();
        run(40);

        // Random traffic.
        for (int i = 0; i < 2000; i++) begin
            valid_in = ($urandom_range(0, 39) == 0);
            ready_in = ($urandom_range(0, 3) != 0);
            set_vec_rand();
            tick();
        end
        valid_in = 1'b0;
        ready_in = 1'b1;
        run(200);
        check_val("drain_cnt", {30'd0, vec_cnt}, 32'd0);
        check_val("drain_valid", {31'd0, valid_out}, 32'd0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/conv1_out_serializer.md
Name: conv1_out_serializer

Overview:
- Sits at the output end of conv1_layer.
- Consumes the 32-channel parallel result vector (conv1_out[0:31], qualified by conv1_layer's valid_out).
- Re-emits it as a 32-bit word stream, one channel per beat, under a valid/ready handshake, for the next layer or memory writer.
- Buffers up to DEPTH vectors because conv1_layer has no backpressure; overflow is flagged, never stalls upstream.

Parameters:
- DATA_W, 32, width of each channel word
- NUM_CH, 32, channels per input vector
- DEPTH, 2, vector buffer entries (power of 2, >=2)

Ports:
- clk  input  1  clock, all logic on rising edge
- rst_n  input  1  asynchronous active-low reset
- valid_in  input  1  vector strobe, driven from conv1_layer valid_out
- vec_in  input  DATA_W x [0:NUM_CH-1]  unpacked channel vector, driven from conv1_layer conv1_out
- data_out  output  DATA_W  current channel word
- valid_out  output  1  data_out/ch_idx/last valid
- ready_in  input  1  downstream accepts beat when valid_out && ready_in
- ch_idx  output  $clog2(NUM_CH)  channel index of data_out
- last  output  1  high on channel NUM_CH-1 beat
- vec_cnt  output  $clog2(DEPTH)+1  vectors currently buffered, including the one being sent
- overflow  output  1  sticky: a vector was dropped

Behaviour:
- Reset (async assert, sync-safe deassert on the next clk edge) clears every output to 0:
  - data_out=0, valid_out=0, ch_idx=0, last=0, vec_cnt=0, overflow=0.
  - Write/read pointers and channel counter are cleared.
  - Buffer contents are don't-care.
- Reset mid-stream aborts the current vector; no further beats until a new valid_in.
- Capture:
  - On a clk edge with valid_in=1 and vec_cnt<DEPTH, all NUM_CH words are written into entry wr_ptr, and wr_ptr increments modulo DEPTH.
  - valid_in=X while 0 is ignored.
- Full:
  - valid_in=1 with vec_cnt==DEPTH drops the vector and sets overflow=1 until reset.
  - Exception: if the same edge completes the final beat of the head vector (valid_out && ready_in && last), the entry is freed and the new vector is accepted; overflow does not set.
- FSM, two states:
  - IDLE: valid_out=0. Moves to SEND on the edge after vec_cnt becomes nonzero.
  - SEND: valid_out=1, data_out=buf[rd_ptr][ch_idx].
    - Beat handshake advances ch_idx.
    - On the last beat, ch_idx wraps to 0 and rd_ptr increments modulo DEPTH.
    - Stays in SEND if another vector is buffered, with no bubble between vectors; otherwise returns to IDLE.
- Latency:
  - Vector captured at edge N gives valid_out=1 with channel 0 from edge N+1.
  - First beat can complete at edge N+2 at the earliest.
- Outputs are registered. data_out, ch_idx and last hold stable while valid_out && !ready_in.
- vec_cnt:
  - +1 on accept, -1 on last-beat handshake, unchanged when both occur on the same edge.
- Pointers wrap modulo DEPTH; the counter is the full/empty authority, with no pointer-compare ambiguity.
- Sustained throughput is 1 word/cycle. Upstream vectors arriving faster than every NUM_CH cycles eventually overflow, by design.

Optional Feature:
- SER_RELU_EN:
  - Defined: each word is interpreted as signed DATA_W and words with MSB=1 are output as 0. The substitution happens at the buffer read, so there is no extra latency. ch_idx, last and the handshake are unchanged.
  - Undefined: words pass through bit-exact.

Test Plan:
1. Reset mid-SEND (rst_n low for 3 ns at ch_idx=5) -> all outputs 0 immediately; then valid_in pulse with vec_in[k]=k -> beats 0..31 with data_out=k, last only at k=31.
2. Single vector, ready_in=1, vec_in[k]=32'h1000+k, captured at edge N -> valid_out from N+1, 32 consecutive beats, then valid_out=0 and vec_cnt=0.
3. Backpressure: ready_in toggles 1,0,0,1 -> data_out/ch_idx stable during the 0 cycles; no beat lost or duplicated across 32 channels.
4. Overflow: ready_in=0, three valid_in pulses (vectors A, B, C) -> vec_cnt=2, overflow=1; after release, the stream is A then B with no bubble and C is absent.
5. Simultaneous: buffer full, valid_in asserted on the edge of A's last beat -> accepted, overflow stays 0, vec_cnt stays 2, output order is B then new vector.
6. SER_RELU_EN defined, vec_in[3]=32'hFFFF_FFF0, vec_in[4]=32'h0000_0010 -> beat 3 outputs 0 and beat 4 outputs 32'h10. Undefined -> both words pass unchanged.
